// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by the fetch and decode stages of the 5-stage LoongArch pipeline.
//   PC_W / INST_W / ADEF_W : field widths of the IF->ID bus {pc, inst, adef}
//   RESET_PC               : address of the first instruction fetched after reset
//   INST_NOP               : andi r0,r0,0, substituted for a faulting fetch
//   pc_misaligned()        : true when a fetch address is not word aligned
package pipe_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int ADEF_W = 1;

  localparam logic [PC_W-1:0]   RESET_PC = 32'h1C00_0000;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0340_0000;

  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// ifu_inst_buf: 1-entry skid buffer for the fetch stage.
// The synchronous SRAM only returns a word for one cycle. When decode stalls in
// that cycle, the word is copied here and presented until it is transferred or
// flushed by a redirect.
// Optional feature macro: IFU_ADEF_EN (adds the address-fault flag of the IF entry).
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   capture_i       copy sram_rdata_i into the buffer this cycle
//   flush_i         drop the buffered word (transfer or redirect); wins over capture
//   sram_rdata_i    SRAM read data of the current IF request
//   load_i          (IFU_ADEF_EN) a new fetch enters IF this cycle
//   load_adef_i     (IFU_ADEF_EN) fault flag of that new fetch
//   inst_o          instruction word of the IF entry
//   adef_o          (IFU_ADEF_EN) fault flag of the IF entry
module ifu_inst_buf
  import pipe_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_WORD = INST_NOP
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              capture_i,
  input  logic              flush_i,
  input  logic [INST_W-1:0] sram_rdata_i,
`ifdef IFU_ADEF_EN
  input  logic              load_i,
  input  logic              load_adef_i,
  output logic              adef_o,
`endif
  output logic [INST_W-1:0] inst_o
);

  logic              buf_valid_q, buf_valid_d;
  logic [INST_W-1:0] buf_q, buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (flush_i) begin
      buf_valid_d = 1'b0;
    end else if (capture_i) begin
      buf_valid_d = 1'b1;
      buf_d       = sram_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) buf_valid_q <= 1'b0;
    else         buf_valid_q <= buf_valid_d;
  end

  // NOTE: the payload has no reset; buf_valid_q qualifies it, and leaving it
  // unreset keeps the data path free of reset fan-out.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef IFU_ADEF_EN
  logic adef_q, adef_d;

  // Flag follows the IF entry: replaced on every fetch, held otherwise.
  always_comb begin
    adef_d = adef_q;
    if (load_i) adef_d = load_adef_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) adef_q <= 1'b0;
    else         adef_q <= adef_d;
  end

  assign adef_o = adef_q;
  assign inst_o = adef_q ? NOP_WORD : (buf_valid_q ? buf_q : sram_rdata_i);
`else
  assign inst_o = buf_valid_q ? buf_q : sram_rdata_i;
`endif

endmodule

// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: instruction-fetch stage of the 5-stage LoongArch pipeline.
// Holds the fetch PC, issues reads to the synchronous instruction SRAM and hands
// {pc, inst} to decode with a valid/allow_in handshake. Decode redirects replace
// the IF instruction. A stalled SRAM word is kept in ifu_inst_buf.
// Optional feature macro: IFU_ADEF_EN (misaligned fetch -> NOP with fault flag).
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   inst_sram_en/we/addr/wdata      SRAM read request (we and wdata are tied to 0)
//   inst_sram_rdata                 SRAM data, valid the cycle after a request
//   IDU_allow_in                    decode accepts this cycle
//   IDU_br_taken_cancel/br_target   redirect pulse and its target address
//   IFU_to_IDU_valid/pc/inst        instruction toward decode
//   IFU_adef_to_IDU                 (IFU_ADEF_EN) fetch-address fault flag
// All outputs read 0 while resetn is low.
module ifu_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0]   FETCH_RESET_PC = RESET_PC,
  parameter logic [INST_W-1:0] FETCH_INST_NOP = INST_NOP
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_sram_en,
  output logic [3:0]        inst_sram_we,
  output logic [PC_W-1:0]   inst_sram_addr,
  output logic [INST_W-1:0] inst_sram_wdata,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              IDU_allow_in,
  input  logic              IDU_br_taken_cancel,
  input  logic [PC_W-1:0]   IDU_br_target,
  output logic              IFU_to_IDU_valid,
  output logic [PC_W-1:0]   IFU_pc_to_IDU,
`ifdef IFU_ADEF_EN
  output logic              IFU_adef_to_IDU,
`endif
  output logic [INST_W-1:0] IFU_inst_to_IDU
);

  logic              if_valid_q, if_valid_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic              rdata_fresh_q, rdata_fresh_d;

  logic [PC_W-1:0]   nextpc;
  logic              if_allow_in;
  logic              fetch_go;
  logic              sram_req;
  logic              to_idu_valid;
  logic              transfer;
  logic [INST_W-1:0] if_inst;

  // Pre-IF: a redirect replaces sequential fetch; +4 wraps at 32 bits.
  assign nextpc = IDU_br_taken_cancel ? IDU_br_target : if_pc_q + 32'd4;

  // A redirect discards the IF entry, so it never waits for decode.
  assign if_allow_in = !if_valid_q | IDU_allow_in | IDU_br_taken_cancel;
  assign fetch_go    = resetn & if_allow_in;

`ifdef IFU_ADEF_EN
  logic if_adef;
  logic nextpc_bad;
  // A misaligned fetch advances the stage but never touches the SRAM.
  assign nextpc_bad = pc_misaligned(nextpc);
  assign sram_req   = fetch_go & !nextpc_bad;
`else
  assign sram_req   = fetch_go;
`endif

  assign to_idu_valid = resetn & if_valid_q & !IDU_br_taken_cancel;
  assign transfer     = to_idu_valid & IDU_allow_in;

  // NOTE: defaults first, so every path assigns every _d signal and no latch
  // can be inferred.
  always_comb begin
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    rdata_fresh_d = sram_req;   // rdata is only trusted the cycle after a real request
    if (fetch_go) begin
      if_valid_d = 1'b1;
      if_pc_d    = nextpc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_valid_q    <= 1'b0;
      if_pc_q       <= FETCH_RESET_PC - 32'd4;
      rdata_fresh_q <= 1'b0;
    end else begin
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      rdata_fresh_q <= rdata_fresh_d;
    end
  end

  // Capture only a word that has not been buffered yet and is about to vanish.
  // Flush wins, so a redirect in the capture cycle never keeps a wrong-path word.
  ifu_inst_buf #(
    .NOP_WORD     (FETCH_INST_NOP)
  ) u_inst_buf (
    .clk          (clk),
    .resetn       (resetn),
    .capture_i    (rdata_fresh_q & if_valid_q & !IDU_allow_in),
    .flush_i      (transfer | IDU_br_taken_cancel),
    .sram_rdata_i (inst_sram_rdata),
`ifdef IFU_ADEF_EN
    .load_i       (fetch_go),
    .load_adef_i  (nextpc_bad),
    .adef_o       (if_adef),
`endif
    .inst_o       (if_inst)
  );

  assign inst_sram_en     = sram_req;
  assign inst_sram_we     = 4'b0;
  assign inst_sram_addr   = resetn ? nextpc : '0;
  assign inst_sram_wdata  = '0;

  assign IFU_to_IDU_valid = to_idu_valid;
  assign IFU_pc_to_IDU    = resetn ? if_pc_q : '0;
  assign IFU_inst_to_IDU  = resetn ? if_inst : '0;
`ifdef IFU_ADEF_EN
  assign IFU_adef_to_IDU  = resetn & if_adef;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
module tb_ifu_fetch_stage;

  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        IDU_allow_in;
  logic        IDU_br_taken_cancel;
  logic [31:0] IDU_br_target;
  logic        IFU_to_IDU_valid;
  logic [31:0] IFU_pc_to_IDU;
  logic [31:0] IFU_inst_to_IDU;
`ifdef IFU_ADEF_EN
  logic        IFU_adef_to_IDU;
`endif

  int total = 0;
  int bad   = 0;

  ifu_fetch_stage dut (
    .clk                 (clk),
    .resetn              (resetn),
    .inst_sram_en        (inst_sram_en),
    .inst_sram_we        (inst_sram_we),
    .inst_sram_addr      (inst_sram_addr),
    .inst_sram_wdata     (inst_sram_wdata),
    .inst_sram_rdata     (inst_sram_rdata),
    .IDU_allow_in        (IDU_allow_in),
    .IDU_br_taken_cancel (IDU_br_taken_cancel),
    .IDU_br_target       (IDU_br_target),
    .IFU_to_IDU_valid    (IFU_to_IDU_valid),
    .IFU_pc_to_IDU       (IFU_pc_to_IDU),
`ifdef IFU_ADEF_EN
    .IFU_adef_to_IDU     (IFU_adef_to_IDU),
`endif
    .IFU_inst_to_IDU     (IFU_inst_to_IDU)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Synchronous SRAM; without a request the data lines carry junk.
  logic [15:0] junk_cnt = '0;
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= {16'hDEAD, junk_cnt};
    junk_cnt <= junk_cnt + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs right after negedge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst_n, input logic allow, input logic cancel, input logic [31:0] tgt);
    @(negedge clk);
    resetn              = rst_n;
    IDU_allow_in        = allow;
    IDU_br_taken_cancel = cancel;
    IDU_br_target       = tgt;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, IFU_to_IDU_valid}, 32'd0);
    check({tag, "_en"},    {31'd0, inst_sram_en},     32'd0);
    check({tag, "_addr"},  inst_sram_addr,            32'd0);
    check({tag, "_pc"},    IFU_pc_to_IDU,             32'd0);
    check({tag, "_inst"},  IFU_inst_to_IDU,           32'd0);
  endtask

  typedef struct {
    logic        allow;
    logic        cancel;
    logic [31:0] target;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;    // checked with its instruction only when exp_valid
  } vec_t;

  function automatic vec_t mk(input logic a, input logic c, input logic [31:0] t,
                              input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc);
    vec_t r;
    r.allow = a; r.cancel = c; r.target = t;
    r.exp_en = en; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
    return r;
  endfunction

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  initial begin
    // Rows 0-2: start-up and streaming. Rows 3-6: 3-cycle stall on 0x..08.
    // Row 7: redirect while IF holds 0x..0C. Rows 10-13: redirect during a stall
    // with a buffered word. Rows 14-16: back-to-back redirects. Rows 17-19: PC wrap.
    vecs[0]  = mk(1, 0, 32'h0,         1, 32'h1C00_0000, 0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0,         1, 32'h1C00_0004, 1, 32'h1C00_0000);
    vecs[2]  = mk(1, 0, 32'h0,         1, 32'h1C00_0008, 1, 32'h1C00_0004);
    vecs[3]  = mk(0, 0, 32'h0,         0, 32'h1C00_000C, 1, 32'h1C00_0008);
    vecs[4]  = mk(0, 0, 32'h0,         0, 32'h1C00_000C, 1, 32'h1C00_0008);
    vecs[5]  = mk(0, 0, 32'h0,         0, 32'h1C00_000C, 1, 32'h1C00_0008);
    vecs[6]  = mk(1, 0, 32'h0,         1, 32'h1C00_000C, 1, 32'h1C00_0008);
    vecs[7]  = mk(1, 1, 32'h1C00_0100, 1, 32'h1C00_0100, 0, 32'h0);
    vecs[8]  = mk(1, 0, 32'h0,         1, 32'h1C00_0104, 1, 32'h1C00_0100);
    vecs[9]  = mk(1, 0, 32'h0,         1, 32'h1C00_0108, 1, 32'h1C00_0104);
    vecs[10] = mk(0, 0, 32'h0,         0, 32'h1C00_010C, 1, 32'h1C00_0108);
    vecs[11] = mk(0, 0, 32'h0,         0, 32'h1C00_010C, 1, 32'h1C00_0108);
    vecs[12] = mk(0, 1, 32'h1C00_0200, 1, 32'h1C00_0200, 0, 32'h0);
    vecs[13] = mk(1, 0, 32'h0,         1, 32'h1C00_0204, 1, 32'h1C00_0200);
    vecs[14] = mk(1, 1, 32'h1C00_0300, 1, 32'h1C00_0300, 0, 32'h0);
    vecs[15] = mk(1, 1, 32'h1C00_0400, 1, 32'h1C00_0400, 0, 32'h0);
    vecs[16] = mk(1, 0, 32'h0,         1, 32'h1C00_0404, 1, 32'h1C00_0400);
    vecs[17] = mk(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[18] = mk(1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    vecs[19] = mk(1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0000_0000);

    resetn = 1'b0; IDU_allow_in = 1'b0; IDU_br_taken_cancel = 1'b0; IDU_br_target = '0;

    // Reset state: outputs all zero while held in reset.
    drive(0, 1, 0, 32'h0);
    drive(0, 1, 0, 32'h0);
    check_all_zero("reset");

    for (int i = 0; i < NVEC; i++) begin
      drive(1, vecs[i].allow, vecs[i].cancel, vecs[i].target);
      check($sformatf("row%0d_en", i),    {31'd0, inst_sram_en},     {31'd0, vecs[i].exp_en});
      check($sformatf("row%0d_addr", i),  inst_sram_addr,            vecs[i].exp_addr);
      check($sformatf("row%0d_valid", i), {31'd0, IFU_to_IDU_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("row%0d_we_wdata", i), {inst_sram_we, inst_sram_wdata[27:0]}, 32'd0);
      if (vecs[i].exp_valid) begin
        check($sformatf("row%0d_pc", i),   IFU_pc_to_IDU,   vecs[i].exp_pc);
        check($sformatf("row%0d_inst", i), IFU_inst_to_IDU, mem_word(vecs[i].exp_pc));
`ifdef IFU_ADEF_EN
        check($sformatf("row%0d_adef", i), {31'd0, IFU_adef_to_IDU}, 32'd0);
`endif
      end
    end

    // Reset mid-stream with a buffered word (pc 0x00000004 stalled one cycle).
    drive(1, 0, 0, 32'h0);
    check("midrst_pre_pc", IFU_pc_to_IDU, 32'h0000_0004);
    drive(0, 0, 0, 32'h0);
    check_all_zero("midrst_a");
    drive(0, 1, 0, 32'h0);
    check_all_zero("midrst_b");
    drive(1, 1, 0, 32'h0);
    check("restart_addr",  inst_sram_addr, 32'h1C00_0000);
    check("restart_en",    {31'd0, inst_sram_en},     32'd1);
    check("restart_valid", {31'd0, IFU_to_IDU_valid}, 32'd0);
    drive(1, 1, 0, 32'h0);
    check("restart_valid2", {31'd0, IFU_to_IDU_valid}, 32'd1);
    check("restart_pc",     IFU_pc_to_IDU,   32'h1C00_0000);
    check("restart_inst",   IFU_inst_to_IDU, mem_word(32'h1C00_0000));

`ifdef IFU_ADEF_EN
    // Misaligned redirect: no SRAM request, NOP with fault flag, flag persists.
    drive(1, 1, 1, 32'h1C00_0102);
    check("adef_redir_en",   {31'd0, inst_sram_en}, 32'd0);
    check("adef_redir_addr", inst_sram_addr,        32'h1C00_0102);
    drive(1, 1, 0, 32'h0);
    check("adef_valid", {31'd0, IFU_to_IDU_valid}, 32'd1);
    check("adef_pc",    IFU_pc_to_IDU,             32'h1C00_0102);
    check("adef_inst",  IFU_inst_to_IDU,           NOP);
    check("adef_flag",  {31'd0, IFU_adef_to_IDU},  32'd1);
    check("adef_en2",   {31'd0, inst_sram_en},     32'd0);
    drive(1, 0, 0, 32'h0);
    check("adef2_pc",   IFU_pc_to_IDU,             32'h1C00_0106);
    check("adef2_inst", IFU_inst_to_IDU,           NOP);
    check("adef2_flag", {31'd0, IFU_adef_to_IDU},  32'd1);
    drive(1, 0, 1, 32'h1C00_0200);
    check("adef_clr_en", {31'd0, inst_sram_en},    32'd1);
    drive(1, 1, 0, 32'h0);
    check("adef_clr_pc",   IFU_pc_to_IDU,            32'h1C00_0200);
    check("adef_clr_inst", IFU_inst_to_IDU,          mem_word(32'h1C00_0200));
    check("adef_clr_flag", {31'd0, IFU_adef_to_IDU}, 32'd0);
`else
    // Without the fault check a misaligned target goes to the SRAM unchanged.
    drive(1, 1, 1, 32'h1C00_0102);
    check("mis_en",   {31'd0, inst_sram_en}, 32'd1);
    check("mis_addr", inst_sram_addr,        32'h1C00_0102);
    drive(1, 1, 0, 32'h0);
    check("mis_pc",   IFU_pc_to_IDU,   32'h1C00_0102);
    check("mis_inst", IFU_inst_to_IDU, mem_word(32'h1C00_0102));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
